// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions for the memory-port arbiter: opcodes, channel
// payload structs and beat-count helpers.
package tl_pkg;

  localparam logic [2:0] TL_GET     = 3'd4;
  localparam logic [2:0] TL_PUTFULL = 3'd0;
  localparam logic [2:0] TL_PUTPART = 3'd1;
  localparam logic [2:0] TL_ACK     = 3'd0;
  localparam logic [2:0] TL_ACKDATA = 3'd1;

  typedef enum logic {
    A_UNLOCKED = 1'b0,
    A_LOCKED   = 1'b1
  } a_state_e;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [31:0] data;
    logic        denied;
    logic        corrupt;
  } tl_d_t;

  // Beats minus one for a 32-bit data bus: sizes up to 4 bytes fit in one beat.
  function automatic logic [7:0] tl_beats(input logic [3:0] size);
    if (size <= 4'd2) return 8'd0;
    return 8'((16'd1 << (size - 4'd2)) - 16'd1);
  endfunction

  function automatic logic tl_is_put(input logic [2:0] opcode);
    return (opcode == TL_PUTFULL) || (opcode == TL_PUTPART);
  endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Down-counter of remaining beats in a burst; 'last' marks the beat that
// completes it.
module tl_beat_counter #(
  parameter int BEAT_W = 3
) (
  input  logic              cpu_clk_i,
  input  logic              cpu_rst_i,
  input  logic              load,
  input  logic [BEAT_W-1:0] load_val,
  input  logic              dec,
  output logic              last
);

  logic [BEAT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of process ordering.
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - BEAT_W'(1);
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/tl_mem_arbiter.sv
// 2:1 TileLink-UL arbiter: page walker (m0) and miss unit (m1) share one memory
// port; round-robin A grant with burst locking, D beats routed by source.
module tl_mem_arbiter
  import tl_pkg::*;
#(
  parameter int MAX_SIZE = 5,
  parameter int BEAT_W   = 3
) (
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_i,

  input  logic [2:0]  m0_a_opcode,
  input  logic [2:0]  m0_a_param,
  input  logic [3:0]  m0_a_size,
  input  logic [31:0] m0_a_address,
  input  logic [3:0]  m0_a_mask,
  input  logic [31:0] m0_a_data,
  input  logic        m0_a_corrupt,
  input  logic        m0_a_valid,
  output logic        m0_a_ready,
  output logic [2:0]  m0_d_opcode,
  output logic [1:0]  m0_d_param,
  output logic [3:0]  m0_d_size,
  output logic [31:0] m0_d_data,
  output logic        m0_d_denied,
  output logic        m0_d_corrupt,
  output logic        m0_d_valid,
  input  logic        m0_d_ready,

  input  logic [2:0]  m1_a_opcode,
  input  logic [2:0]  m1_a_param,
  input  logic [3:0]  m1_a_size,
  input  logic [31:0] m1_a_address,
  input  logic [3:0]  m1_a_mask,
  input  logic [31:0] m1_a_data,
  input  logic        m1_a_corrupt,
  input  logic        m1_a_valid,
  output logic        m1_a_ready,
  output logic [2:0]  m1_d_opcode,
  output logic [1:0]  m1_d_param,
  output logic [3:0]  m1_d_size,
  output logic [31:0] m1_d_data,
  output logic        m1_d_denied,
  output logic        m1_d_corrupt,
  output logic        m1_d_valid,
  input  logic        m1_d_ready,

  output logic [2:0]  s_a_opcode,
  output logic [2:0]  s_a_param,
  output logic [3:0]  s_a_size,
  output logic [31:0] s_a_address,
  output logic [3:0]  s_a_mask,
  output logic [31:0] s_a_data,
  output logic        s_a_corrupt,
  output logic        s_a_source,
  output logic        s_a_valid,
  input  logic        s_a_ready,

  input  logic [2:0]  s_d_opcode,
  input  logic [1:0]  s_d_param,
  input  logic [3:0]  s_d_size,
  input  logic [31:0] s_d_data,
  input  logic        s_d_denied,
  input  logic        s_d_corrupt,
  input  logic        s_d_source,
  input  logic        s_d_valid,
  output logic        s_d_ready,

  output logic        unexpected_d_o
);

  tl_a_t       m_a [2];
  tl_a_t       s_a;
  tl_d_t       s_d;
  logic [1:0]  m_a_valid, m_d_ready, elig, a_ready, d_valid;

  a_state_e    state_q, state_d;
  logic        owner_q, owner_d;
  logic        rr_last_q, rr_last_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic        unexpected_q, unexpected_d;

  logic              grant;
  logic              a_fire, a_multi, a_final, a_last;
  logic              d_fire;
  logic [1:0]        d_last;
  logic [BEAT_W-1:0] a_beats_m1, d_beats_m1;

  assign m_a[0] = {m0_a_opcode, m0_a_param, m0_a_size, m0_a_address,
                   m0_a_mask, m0_a_data, m0_a_corrupt};
  assign m_a[1] = {m1_a_opcode, m1_a_param, m1_a_size, m1_a_address,
                   m1_a_mask, m1_a_data, m1_a_corrupt};
  assign m_a_valid = {m1_a_valid, m0_a_valid};
  assign m_d_ready = {m1_d_ready, m0_d_ready};
  assign elig      = m_a_valid & ~outstanding_q;

  assign s_a = m_a[grant];
  assign {s_a_opcode, s_a_param, s_a_size, s_a_address,
          s_a_mask, s_a_data, s_a_corrupt} = s_a;
  assign s_a_source = grant;

  // D payload is broadcast; only the valid is steered.
  assign s_d = {s_d_opcode, s_d_param, s_d_size, s_d_data, s_d_denied, s_d_corrupt};
  assign {m0_d_opcode, m0_d_param, m0_d_size, m0_d_data, m0_d_denied, m0_d_corrupt} = s_d;
  assign {m1_d_opcode, m1_d_param, m1_d_size, m1_d_data, m1_d_denied, m1_d_corrupt} = s_d;
  assign {m1_a_ready, m0_a_ready} = a_ready;
  assign {m1_d_valid, m0_d_valid} = d_valid;
  assign unexpected_d_o = unexpected_q;

  assign a_beats_m1 = tl_is_put(s_a.opcode)    ? BEAT_W'(tl_beats(s_a.size)) : '0;
  assign d_beats_m1 = (s_a.opcode == TL_GET)   ? BEAT_W'(tl_beats(s_a.size)) : '0;
  assign a_multi    = (a_beats_m1 != '0);
  assign a_fire     = s_a_valid && s_a_ready;
  assign a_final    = a_fire && ((state_q == A_LOCKED) ? a_last : !a_multi);
  assign d_fire     = s_d_valid && s_d_ready && outstanding_q[s_d_source];

  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      state_q       <= A_UNLOCKED;
      owner_q       <= 1'b0;
      rr_last_q     <= 1'b1;
      outstanding_q <= '0;
      unexpected_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_last_q     <= rr_last_d;
      outstanding_q <= outstanding_d;
      unexpected_q  <= unexpected_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves a
  // value held, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_last_d     = rr_last_q;
    outstanding_d = outstanding_q;
    case (state_q)
      A_UNLOCKED: if (a_fire && a_multi) begin
        state_d = A_LOCKED;
        owner_d = grant;
      end
      A_LOCKED:   if (a_fire && a_last) state_d = A_UNLOCKED;
      default:    state_d = A_UNLOCKED;
    endcase
    if (a_final) begin
      outstanding_d[grant] = 1'b1;
      rr_last_d            = grant;
    end
    // Set and clear never target the same master: A needs outstanding clear.
    if (d_fire && d_last[s_d_source]) outstanding_d[s_d_source] = 1'b0;
    unexpected_d = s_d_valid && !outstanding_q[s_d_source];
  end

  always_comb begin
    grant = 1'b0;
    if (state_q == A_LOCKED)  grant = owner_q;
    else if (&elig)           grant = ~rr_last_q;
    else if (elig[1])         grant = 1'b1;
    s_a_valid        = elig[grant];
    a_ready          = '0;
    a_ready[grant]   = s_a_ready && elig[grant];
    d_valid          = '0;
    d_valid[s_d_source] = s_d_valid && outstanding_q[s_d_source];
    // Beats for a source with nothing outstanding are swallowed.
    s_d_ready = outstanding_q[s_d_source] ? m_d_ready[s_d_source] : 1'b1;
  end

  tl_beat_counter #(.BEAT_W(BEAT_W)) u_a_cnt (
    .cpu_clk_i (cpu_clk_i),
    .cpu_rst_i (cpu_rst_i),
    .load      (a_fire && (state_q == A_UNLOCKED) && a_multi),
    .load_val  (a_beats_m1 - BEAT_W'(1)),
    .dec       (a_fire && (state_q == A_LOCKED)),
    .last      (a_last)
  );

  for (genvar i = 0; i < 2; i++) begin : g_d_cnt
    tl_beat_counter #(.BEAT_W(BEAT_W)) u_d_cnt (
      .cpu_clk_i (cpu_clk_i),
      .cpu_rst_i (cpu_rst_i),
      .load      (a_final && (grant == 1'(i))),
      .load_val  (d_beats_m1),
      .dec       (d_fire && (s_d_source == 1'(i))),
      .last      (d_last[i])
    );
  end

  a_size_legal: assert property (@(posedge cpu_clk_i) disable iff (cpu_rst_i)
    s_a_valid |-> (s_a_size <= 4'(MAX_SIZE)));

endmodule

// File: tb/tb_tl_mem_arbiter.sv
// Directed self-checking bench for tl_mem_arbiter: arbitration, burst lock,
// D routing, outstanding blocking, unexpected D and mid-burst reset.
module tb_tl_mem_arbiter;
  import tl_pkg::*;

  logic        cpu_clk_i, cpu_rst_i;
  logic [2:0]  m0_a_opcode, m0_a_param, m1_a_opcode, m1_a_param;
  logic [3:0]  m0_a_size, m0_a_mask, m1_a_size, m1_a_mask;
  logic [31:0] m0_a_address, m0_a_data, m1_a_address, m1_a_data;
  logic        m0_a_corrupt, m0_a_valid, m0_a_ready, m1_a_corrupt, m1_a_valid, m1_a_ready;
  logic [2:0]  m0_d_opcode, m1_d_opcode;
  logic [1:0]  m0_d_param, m1_d_param;
  logic [3:0]  m0_d_size, m1_d_size;
  logic [31:0] m0_d_data, m1_d_data;
  logic        m0_d_denied, m0_d_corrupt, m0_d_valid, m0_d_ready;
  logic        m1_d_denied, m1_d_corrupt, m1_d_valid, m1_d_ready;
  logic [2:0]  s_a_opcode, s_a_param;
  logic [3:0]  s_a_size, s_a_mask;
  logic [31:0] s_a_address, s_a_data;
  logic        s_a_corrupt, s_a_source, s_a_valid, s_a_ready;
  logic [2:0]  s_d_opcode;
  logic [1:0]  s_d_param;
  logic [3:0]  s_d_size;
  logic [31:0] s_d_data;
  logic        s_d_denied, s_d_corrupt, s_d_source, s_d_valid, s_d_ready;
  logic        unexpected_d_o;

  int n_cmp = 0;
  int n_err = 0;

  tl_mem_arbiter #(.MAX_SIZE(5), .BEAT_W(3)) dut (
    .cpu_clk_i(cpu_clk_i), .cpu_rst_i(cpu_rst_i),
    .m0_a_opcode(m0_a_opcode), .m0_a_param(m0_a_param), .m0_a_size(m0_a_size),
    .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
    .m0_a_corrupt(m0_a_corrupt), .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready),
    .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param), .m0_d_size(m0_d_size),
    .m0_d_data(m0_d_data), .m0_d_denied(m0_d_denied), .m0_d_corrupt(m0_d_corrupt),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
    .m1_a_opcode(m1_a_opcode), .m1_a_param(m1_a_param), .m1_a_size(m1_a_size),
    .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
    .m1_a_corrupt(m1_a_corrupt), .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready),
    .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param), .m1_d_size(m1_d_size),
    .m1_d_data(m1_d_data), .m1_d_denied(m1_d_denied), .m1_d_corrupt(m1_d_corrupt),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
    .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
    .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
    .s_a_corrupt(s_a_corrupt), .s_a_source(s_a_source), .s_a_valid(s_a_valid),
    .s_a_ready(s_a_ready),
    .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
    .s_d_data(s_d_data), .s_d_denied(s_d_denied), .s_d_corrupt(s_d_corrupt),
    .s_d_source(s_d_source), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
    .unexpected_d_o(unexpected_d_o)
  );

  initial cpu_clk_i = 1'b0;
  always #5 cpu_clk_i = ~cpu_clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic set_a(input int m, input logic [2:0] op, input logic [3:0] sz,
                       input logic [31:0] addr, input logic [31:0] data);
    if (m == 0) begin
      m0_a_opcode = op; m0_a_param = 3'd0; m0_a_size = sz; m0_a_address = addr;
      m0_a_mask = 4'hF; m0_a_data = data; m0_a_corrupt = 1'b0; m0_a_valid = 1'b1;
    end else begin
      m1_a_opcode = op; m1_a_param = 3'd0; m1_a_size = sz; m1_a_address = addr;
      m1_a_mask = 4'hF; m1_a_data = data; m1_a_corrupt = 1'b0; m1_a_valid = 1'b1;
    end
  endtask

  task automatic clr_a(input int m);
    if (m == 0) m0_a_valid = 1'b0;
    else        m1_a_valid = 1'b0;
  endtask

  task automatic set_d(input logic src, input logic [2:0] op, input logic [3:0] sz,
                       input logic [31:0] data, input logic den);
    s_d_source = src; s_d_opcode = op; s_d_param = 2'd0; s_d_size = sz;
    s_d_data = data; s_d_denied = den; s_d_corrupt = 1'b0; s_d_valid = 1'b1;
  endtask

  task automatic clr_d();
    s_d_valid = 1'b0; s_d_source = 1'b0; s_d_denied = 1'b0;
  endtask

  task automatic idle();
    set_a(0, TL_GET, 4'd2, 32'h0, 32'h0); set_a(1, TL_GET, 4'd2, 32'h0, 32'h0);
    clr_a(0); clr_a(1);
    set_d(1'b0, TL_ACK, 4'd0, 32'h0, 1'b0); clr_d();
    s_a_ready = 1'b1; m0_d_ready = 1'b1; m1_d_ready = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge cpu_clk_i);
    idle();
    cpu_rst_i = 1'b1;
    repeat (2) @(negedge cpu_clk_i);
    cpu_rst_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    cpu_rst_i = 1'b1;
    apply_reset();
    #1;
    if (s_a_valid !== 1'b0) begin $display("FAIL rst_s_a_valid got=%0h exp=0", s_a_valid); n_err++; end n_cmp++;
    if (m0_a_ready !== 1'b0) begin $display("FAIL rst_m0_a_ready got=%0h exp=0", m0_a_ready); n_err++; end n_cmp++;
    if (m1_a_ready !== 1'b0) begin $display("FAIL rst_m1_a_ready got=%0h exp=0", m1_a_ready); n_err++; end n_cmp++;
    if (m0_d_valid !== 1'b0) begin $display("FAIL rst_m0_d_valid got=%0h exp=0", m0_d_valid); n_err++; end n_cmp++;
    if (m1_d_valid !== 1'b0) begin $display("FAIL rst_m1_d_valid got=%0h exp=0", m1_d_valid); n_err++; end n_cmp++;
    if (unexpected_d_o !== 1'b0) begin $display("FAIL rst_unexpected got=%0h exp=0", unexpected_d_o); n_err++; end n_cmp++;
  endtask

  task automatic test_round_robin();
    apply_reset();
    set_a(0, TL_GET, 4'd2, 32'h1000, 32'h0);
    set_a(1, TL_GET, 4'd2, 32'h2000, 32'h0);
    #1;
    if (s_a_valid !== 1'b1) begin $display("FAIL rr_first_valid got=%0h exp=1", s_a_valid); n_err++; end n_cmp++;
    if (s_a_source !== 1'b0) begin $display("FAIL rr_first_src got=%0h exp=0", s_a_source); n_err++; end n_cmp++;
    if (s_a_address !== 32'h1000) begin $display("FAIL rr_first_addr got=%0h exp=1000", s_a_address); n_err++; end n_cmp++;
    if (m0_a_ready !== 1'b1) begin $display("FAIL rr_first_m0_ready got=%0h exp=1", m0_a_ready); n_err++; end n_cmp++;
    if (m1_a_ready !== 1'b0) begin $display("FAIL rr_first_m1_ready got=%0h exp=0", m1_a_ready); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); clr_a(0); #1;
    if (s_a_source !== 1'b1) begin $display("FAIL rr_second_src got=%0h exp=1", s_a_source); n_err++; end n_cmp++;
    if (s_a_address !== 32'h2000) begin $display("FAIL rr_second_addr got=%0h exp=2000", s_a_address); n_err++; end n_cmp++;
    if (m1_a_ready !== 1'b1) begin $display("FAIL rr_second_m1_ready got=%0h exp=1", m1_a_ready); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); clr_a(1);
    set_d(1'b0, TL_ACKDATA, 4'd2, 32'hDEAD0000, 1'b0); #1;
    if (m0_d_valid !== 1'b1) begin $display("FAIL rr_d0_valid got=%0h exp=1", m0_d_valid); n_err++; end n_cmp++;
    if (m0_d_data !== 32'hDEAD0000) begin $display("FAIL rr_d0_data got=%0h exp=dead0000", m0_d_data); n_err++; end n_cmp++;
    if (m0_d_opcode !== TL_ACKDATA) begin $display("FAIL rr_d0_opcode got=%0h exp=1", m0_d_opcode); n_err++; end n_cmp++;
    if (m1_d_valid !== 1'b0) begin $display("FAIL rr_d0_m1_valid got=%0h exp=0", m1_d_valid); n_err++; end n_cmp++;
    if (s_d_ready !== 1'b1) begin $display("FAIL rr_d0_s_ready got=%0h exp=1", s_d_ready); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); set_d(1'b1, TL_ACKDATA, 4'd2, 32'hBEEF0001, 1'b0); #1;
    if (m1_d_valid !== 1'b1) begin $display("FAIL rr_d1_valid got=%0h exp=1", m1_d_valid); n_err++; end n_cmp++;
    if (m1_d_data !== 32'hBEEF0001) begin $display("FAIL rr_d1_data got=%0h exp=beef0001", m1_d_data); n_err++; end n_cmp++;
    if (m0_d_valid !== 1'b0) begin $display("FAIL rr_d1_m0_valid got=%0h exp=0", m0_d_valid); n_err++; end n_cmp++;
    // m0 alone moves the round-robin pointer to m0, so the next tie goes to m1.
    @(negedge cpu_clk_i); clr_d(); set_a(0, TL_GET, 4'd2, 32'h1004, 32'h0);
    @(negedge cpu_clk_i); clr_a(0); set_d(1'b0, TL_ACKDATA, 4'd2, 32'h11, 1'b0);
    @(negedge cpu_clk_i); clr_d();
    set_a(0, TL_GET, 4'd2, 32'h1008, 32'h0);
    set_a(1, TL_GET, 4'd2, 32'h2008, 32'h0); #1;
    if (s_a_source !== 1'b1) begin $display("FAIL rr_tie2_src got=%0h exp=1", s_a_source); n_err++; end n_cmp++;
    if (m0_a_ready !== 1'b0) begin $display("FAIL rr_tie2_m0_ready got=%0h exp=0", m0_a_ready); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); clr_a(0); clr_a(1);
  endtask

  task automatic test_put_burst();
    apply_reset();
    set_a(1, TL_PUTFULL, 4'd4, 32'h3000, 32'hA0); #1;
    if (m1_a_ready !== 1'b1) begin $display("FAIL put_b0_m1_ready got=%0h exp=1", m1_a_ready); n_err++; end n_cmp++;
    if (s_a_source !== 1'b1) begin $display("FAIL put_b0_src got=%0h exp=1", s_a_source); n_err++; end n_cmp++;
    @(negedge cpu_clk_i);
    set_a(0, TL_GET, 4'd2, 32'h1000, 32'h0);
    for (int k = 1; k < 4; k++) begin
      set_a(1, TL_PUTFULL, 4'd4, 32'h3000, 32'hA0 + 32'(k));
      if (k == 2) begin
        s_a_ready = 1'b0; #1;
        if (s_a_source !== 1'b1) begin $display("FAIL put_stall_src got=%0h exp=1", s_a_source); n_err++; end n_cmp++;
        if (m1_a_ready !== 1'b0) begin $display("FAIL put_stall_m1_ready got=%0h exp=0", m1_a_ready); n_err++; end n_cmp++;
        @(negedge cpu_clk_i); s_a_ready = 1'b1;
      end
      #1;
      if (s_a_source !== 1'b1) begin $display("FAIL put_b%0d_src got=%0h exp=1", k, s_a_source); n_err++; end n_cmp++;
      if (s_a_data !== 32'hA0 + 32'(k)) begin $display("FAIL put_b%0d_data got=%0h exp=%0h", k, s_a_data, 32'hA0 + 32'(k)); n_err++; end n_cmp++;
      if (m1_a_ready !== 1'b1) begin $display("FAIL put_b%0d_m1_ready got=%0h exp=1", k, m1_a_ready); n_err++; end n_cmp++;
      if (m0_a_ready !== 1'b0) begin $display("FAIL put_b%0d_m0_ready got=%0h exp=0", k, m0_a_ready); n_err++; end n_cmp++;
      @(negedge cpu_clk_i);
    end
    clr_a(1); #1;
    if (s_a_source !== 1'b0) begin $display("FAIL put_after_src got=%0h exp=0", s_a_source); n_err++; end n_cmp++;
    if (m0_a_ready !== 1'b1) begin $display("FAIL put_after_m0_ready got=%0h exp=1", m0_a_ready); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); clr_a(0);
    set_d(1'b1, TL_ACK, 4'd4, 32'h0, 1'b0); #1;
    if (m1_d_valid !== 1'b1) begin $display("FAIL put_ack_valid got=%0h exp=1", m1_d_valid); n_err++; end n_cmp++;
    if (m1_d_opcode !== TL_ACK) begin $display("FAIL put_ack_opcode got=%0h exp=0", m1_d_opcode); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); clr_d();
  endtask

  task automatic test_get_burst_d();
    int acc;
    apply_reset();
    set_a(1, TL_GET, 4'd5, 32'h4000, 32'h0); #1;
    if (m1_a_ready !== 1'b1) begin $display("FAIL getb_req_ready got=%0h exp=1", m1_a_ready); n_err++; end n_cmp++;
    @(negedge cpu_clk_i);
    set_a(1, TL_GET, 4'd2, 32'h4100, 32'h0);
    acc = 0;
    for (int c = 0; c < 20 && acc < 8; c++) begin
      set_d(1'b1, TL_ACKDATA, 4'd5, 32'h100 + 32'(acc), acc == 3);
      m1_d_ready = (c % 2 == 1);
      #1;
      if (m1_d_valid !== 1'b1) begin $display("FAIL getb_c%0d_valid got=%0h exp=1", c, m1_d_valid); n_err++; end n_cmp++;
      if (m1_d_data !== 32'h100 + 32'(acc)) begin $display("FAIL getb_c%0d_data got=%0h exp=%0h", c, m1_d_data, 32'h100 + 32'(acc)); n_err++; end n_cmp++;
      if (s_d_ready !== m1_d_ready) begin $display("FAIL getb_c%0d_s_ready got=%0h exp=%0h", c, s_d_ready, m1_d_ready); n_err++; end n_cmp++;
      if (m1_a_ready !== 1'b0) begin $display("FAIL getb_c%0d_a_ready got=%0h exp=0", c, m1_a_ready); n_err++; end n_cmp++;
      if (m0_d_valid !== 1'b0) begin $display("FAIL getb_c%0d_m0_valid got=%0h exp=0", c, m0_d_valid); n_err++; end n_cmp++;
      if (acc == 3 && m1_d_denied !== 1'b1) begin $display("FAIL getb_denied got=%0h exp=1", m1_d_denied); n_err++; end
      if (acc == 3) n_cmp++;
      if (m1_d_ready) acc++;
      @(negedge cpu_clk_i);
    end
    if (acc !== 8) begin $display("FAIL getb_beat_budget got=%0d exp=8", acc); n_err++; end n_cmp++;
    clr_d(); m1_d_ready = 1'b1; #1;
    if (m1_a_ready !== 1'b1) begin $display("FAIL getb_next_ready got=%0h exp=1", m1_a_ready); n_err++; end n_cmp++;
    if (s_a_address !== 32'h4100) begin $display("FAIL getb_next_addr got=%0h exp=4100", s_a_address); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); clr_a(1);
  endtask

  task automatic test_outstanding_block();
    apply_reset();
    set_a(0, TL_GET, 4'd2, 32'h5000, 32'h0); #1;
    if (m0_a_ready !== 1'b1) begin $display("FAIL ob_first_ready got=%0h exp=1", m0_a_ready); n_err++; end n_cmp++;
    @(negedge cpu_clk_i);
    set_a(0, TL_GET, 4'd2, 32'h5004, 32'h0);
    set_a(1, TL_GET, 4'd3, 32'h6000, 32'h0); #1;
    if (m0_a_ready !== 1'b0) begin $display("FAIL ob_m0_blocked got=%0h exp=0", m0_a_ready); n_err++; end n_cmp++;
    if (s_a_source !== 1'b1) begin $display("FAIL ob_m1_src got=%0h exp=1", s_a_source); n_err++; end n_cmp++;
    if (s_a_address !== 32'h6000) begin $display("FAIL ob_m1_addr got=%0h exp=6000", s_a_address); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); clr_a(1);
    set_d(1'b1, TL_ACKDATA, 4'd3, 32'h61, 1'b0); #1;
    if (m1_d_valid !== 1'b1) begin $display("FAIL ob_d1a_valid got=%0h exp=1", m1_d_valid); n_err++; end n_cmp++;
    if (s_a_valid !== 1'b0) begin $display("FAIL ob_s_a_valid got=%0h exp=0", s_a_valid); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); set_d(1'b1, TL_ACKDATA, 4'd3, 32'h62, 1'b0); #1;
    if (m1_d_valid !== 1'b1) begin $display("FAIL ob_d1b_valid got=%0h exp=1", m1_d_valid); n_err++; end n_cmp++;
    if (m1_d_data !== 32'h62) begin $display("FAIL ob_d1b_data got=%0h exp=62", m1_d_data); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); set_d(1'b0, TL_ACKDATA, 4'd2, 32'h50, 1'b0); #1;
    if (m0_d_valid !== 1'b1) begin $display("FAIL ob_d0_valid got=%0h exp=1", m0_d_valid); n_err++; end n_cmp++;
    if (m0_a_ready !== 1'b0) begin $display("FAIL ob_no_bypass got=%0h exp=0", m0_a_ready); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); clr_d(); #1;
    if (m0_a_ready !== 1'b1) begin $display("FAIL ob_m0_released got=%0h exp=1", m0_a_ready); n_err++; end n_cmp++;
    if (s_a_address !== 32'h5004) begin $display("FAIL ob_m0_addr got=%0h exp=5004", s_a_address); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); clr_a(0);
  endtask

  task automatic test_unexpected_d();
    apply_reset();
    set_d(1'b1, TL_ACKDATA, 4'd2, 32'h77, 1'b0); #1;
    if (s_d_ready !== 1'b1) begin $display("FAIL unx_s_ready got=%0h exp=1", s_d_ready); n_err++; end n_cmp++;
    if (m1_d_valid !== 1'b0) begin $display("FAIL unx_m1_valid got=%0h exp=0", m1_d_valid); n_err++; end n_cmp++;
    if (m0_d_valid !== 1'b0) begin $display("FAIL unx_m0_valid got=%0h exp=0", m0_d_valid); n_err++; end n_cmp++;
    if (unexpected_d_o !== 1'b0) begin $display("FAIL unx_same_cycle got=%0h exp=0", unexpected_d_o); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); clr_d(); #1;
    if (unexpected_d_o !== 1'b1) begin $display("FAIL unx_pulse got=%0h exp=1", unexpected_d_o); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); #1;
    if (unexpected_d_o !== 1'b0) begin $display("FAIL unx_pulse_end got=%0h exp=0", unexpected_d_o); n_err++; end n_cmp++;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    // Leave m0 outstanding and the pointer on m0, then lock the port to m1.
    set_a(0, TL_GET, 4'd2, 32'h7000, 32'h0);
    @(negedge cpu_clk_i); clr_a(0);
    set_a(1, TL_PUTFULL, 4'd4, 32'h8000, 32'hB0);
    @(negedge cpu_clk_i); set_a(1, TL_PUTFULL, 4'd4, 32'h8000, 32'hB1);
    @(negedge cpu_clk_i); set_a(1, TL_PUTFULL, 4'd4, 32'h8000, 32'hB2);
    set_a(0, TL_GET, 4'd2, 32'h7100, 32'h0);
    cpu_rst_i = 1'b1;
    @(negedge cpu_clk_i); cpu_rst_i = 1'b0;
    set_a(1, TL_GET, 4'd2, 32'h8100, 32'h0); #1;
    if (s_a_source !== 1'b0) begin $display("FAIL rmb_tie_src got=%0h exp=0", s_a_source); n_err++; end n_cmp++;
    if (m0_a_ready !== 1'b1) begin $display("FAIL rmb_m0_ready got=%0h exp=1", m0_a_ready); n_err++; end n_cmp++;
    if (m1_a_ready !== 1'b0) begin $display("FAIL rmb_m1_ready got=%0h exp=0", m1_a_ready); n_err++; end n_cmp++;
    if (s_a_address !== 32'h7100) begin $display("FAIL rmb_addr got=%0h exp=7100", s_a_address); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); clr_a(0); #1;
    if (s_a_source !== 1'b1) begin $display("FAIL rmb_m1_src got=%0h exp=1", s_a_source); n_err++; end n_cmp++;
    if (m1_a_ready !== 1'b1) begin $display("FAIL rmb_m1_next got=%0h exp=1", m1_a_ready); n_err++; end n_cmp++;
    @(negedge cpu_clk_i); clr_a(1);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_put_burst();
    test_get_burst_d();
    test_outstanding_block();
    test_unexpected_d();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
